// File: rtl/pwm_loader.sv
// pwm_loader: fetches a frame of drive words from BRAM, converts intensity to
// pulse width, bursts the beats into the PWM preconditioner, then issues one
// UPDATE strobe on the PWM period boundary once the preconditioner is done.
module pwm_loader #(
  parameter int DEPTH       = 249,
  parameter int MEM_LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [8:0]  TIME_CNT,
  input  logic        START,
  output logic        BUSY,
  output logic        RD_EN,
  output logic [7:0]  ADDR,
  input  logic [15:0] RDATA,
  output logic        DIN_VALID,
  output logic [8:0]  PULSE_WIDTH,
  output logic [7:0]  PHASE,
  input  logic        PWM_DONE,
  output logic        UPDATE
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    DRAIN,
    WAIT_DONE,
    WAIT_SYNC
  } state_t;

  localparam logic [7:0] LAST_ADDR  = 8'(DEPTH - 1);
  localparam logic [2:0] DRAIN_LAST = 3'(MEM_LATENCY);

  state_t                 state, state_next;
  logic                   pending, pending_next;
  logic                   rd_en_next;
  logic [7:0]             addr_next;
  logic                   update_next;
  logic [2:0]             drain_cnt, drain_cnt_next;
  logic [MEM_LATENCY-1:0] valid_pipe;

  // Next-state and next-output decode; every output is registered below, so
  // UPDATE is scheduled one cycle early (TIME_CNT==510) to land on 511.
  always_comb begin
    state_next     = state;
    pending_next   = pending | START;
    rd_en_next     = 1'b0;
    addr_next      = ADDR;
    update_next    = 1'b0;
    drain_cnt_next = drain_cnt;
    case (state)
      IDLE: begin
        if (START || pending) begin
          state_next   = READ;
          rd_en_next   = 1'b1;
          addr_next    = 8'd0;
          pending_next = 1'b0;
        end
      end
      READ: begin
        if (ADDR == LAST_ADDR) begin
          state_next     = DRAIN;
          drain_cnt_next = 3'd0;
        end else begin
          rd_en_next = 1'b1;
          addr_next  = ADDR + 8'd1;
        end
      end
      DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          state_next = WAIT_DONE;
        end else begin
          drain_cnt_next = drain_cnt + 3'd1;
        end
      end
      WAIT_DONE: begin
        if (PWM_DONE) begin
          state_next = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        if (UPDATE) begin
          state_next = IDLE;
        end else if (TIME_CNT == 9'd510) begin
          update_next = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Control register bank: state, pending request, read port and strobe.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      pending   <= 1'b0;
      RD_EN     <= 1'b0;
      ADDR      <= 8'd0;
      UPDATE    <= 1'b0;
      BUSY      <= 1'b0;
      drain_cnt <= 3'd0;
    end else begin
      state     <= state_next;
      pending   <= pending_next;
      RD_EN     <= rd_en_next;
      ADDR      <= addr_next;
      UPDATE    <= update_next;
      BUSY      <= (state_next != IDLE);
      drain_cnt <= drain_cnt_next;
    end
  end

  // Data path: track read latency, then convert intensity with rounding so
  // 255 maps to exactly 256 (50% duty) and capture the phase alongside.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_pipe  <= '0;
      DIN_VALID   <= 1'b0;
      PULSE_WIDTH <= 9'd0;
      PHASE       <= 8'd0;
    end else begin
      valid_pipe[0] <= RD_EN;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
      end
      DIN_VALID <= valid_pipe[MEM_LATENCY-1];
      if (valid_pipe[MEM_LATENCY-1]) begin
        PULSE_WIDTH <= {1'b0, RDATA[15:8]} + {8'd0, RDATA[15]};
        PHASE       <= RDATA[7:0];
      end
    end
  end

endmodule
